ram_arbiter: RTL

Shares the single-port data RAM between two requesters: the CPU memory path (port A, driven by the control unit's MAR/MDR sequence) and the program loader / debug port (port B). It is a four-state sequencer that latches one request at a time, drives the RAM strobes for exactly one cycle, captures read data, and returns a one-cycle `done` to the owner. Port A has priority, but a starvation counter guarantees port B a grant after a bounded number of losses.

---
 rtl/ram_arbiter_if.sv | 49 ++++
 rtl/ram_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the data-RAM arbiter, its two requesters and the RAM.
// The slave view belongs to the arbiter; the master view to requesters and RAM.
interface ram_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_done;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_done;
    logic [DATA_W-1:0] b_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_read;
    logic              ram_write;
    logic [DATA_W-1:0] ram_rdata;

    logic              busy;
    logic              owner;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_done, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_done, b_rdata,
        output ram_addr, ram_wdata, ram_read, ram_write,
        input  ram_rdata,
        output busy, owner
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_done, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_done, b_rdata,
        input  ram_addr, ram_wdata, ram_read, ram_write,
        output ram_rdata,
        input  busy, owner
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter for the single-port data RAM: A has priority,
// B is guaranteed a grant after STARVE_LIMIT consecutive losses.
module ram_arbiter #(
    parameter int ADDR_W       = 9,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input logic          clk,
    input logic          clr,
    ram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t            state, stateNext;
    logic [ADDR_W-1:0] ramAddr, addrNext;
    logic [DATA_W-1:0] ramWdata, wdataNext;
    logic              ramRead, readNext;
    logic              ramWrite, writeNext;
    logic              aDone, aDoneNext;
    logic              bDone, bDoneNext;
    logic [DATA_W-1:0] aRdata, aRdNext;
    logic [DATA_W-1:0] bRdata, bRdNext;
    logic              busyQ, busyNext;
    logic              ownerQ, ownerNext;
    logic [3:0]        starveCnt, cntNext;

    logic anyReq;
    logic pickB;
    logic weSel;

    assign anyReq = bus.a_req | bus.b_req;
    assign pickB  = bus.b_req & (~bus.a_req | (starveCnt == LIMIT));

    always_comb begin
        stateNext = state;
        addrNext  = ramAddr;
        wdataNext = ramWdata;
        readNext  = 1'b0;
        writeNext = 1'b0;
        aDoneNext = 1'b0;
        bDoneNext = 1'b0;
        aRdNext   = aRdata;
        bRdNext   = bRdata;
        ownerNext = ownerQ;
        cntNext   = starveCnt;
        weSel     = 1'b0;

        unique case (state)
            IDLE: begin
                if (anyReq) begin
                    stateNext = ISSUE;
                    ownerNext = pickB;
                    unique case (1'b1)
                        pickB: begin
                            addrNext  = bus.b_addr;
                            wdataNext = bus.b_wdata;
                            weSel     = bus.b_we;
                            cntNext   = 4'd0;
                        end
                        default: begin
                            addrNext  = bus.a_addr;
                            wdataNext = bus.a_wdata;
                            weSel     = bus.a_we;
                            // Only a contested win counts toward starvation.
                            if (bus.b_req && starveCnt != LIMIT)
                                cntNext = starveCnt + 4'd1;
                        end
                    endcase
                    readNext  = ~weSel;
                    writeNext = weSel;
                end
            end
            ISSUE: begin
                if (ramRead) begin
                    stateNext = WAIT;
                end else begin
                    stateNext = RESP;
                    aDoneNext = ~ownerQ;
                    bDoneNext = ownerQ;
                end
            end
            WAIT: begin
                stateNext = RESP;
                aDoneNext = ~ownerQ;
                bDoneNext = ownerQ;
                if (ownerQ) bRdNext = bus.ram_rdata;
                else        aRdNext = bus.ram_rdata;
            end
            RESP: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        busyNext = (stateNext != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state     <= IDLE;
            ramAddr   <= '0;
            ramWdata  <= '0;
            ramRead   <= 1'b0;
            ramWrite  <= 1'b0;
            aDone     <= 1'b0;
            bDone     <= 1'b0;
            aRdata    <= '0;
            bRdata    <= '0;
            busyQ     <= 1'b0;
            ownerQ    <= 1'b0;
            starveCnt <= 4'd0;
        end else begin
            state     <= stateNext;
            ramAddr   <= addrNext;
            ramWdata  <= wdataNext;
            ramRead   <= readNext;
            ramWrite  <= writeNext;
            aDone     <= aDoneNext;
            bDone     <= bDoneNext;
            aRdata    <= aRdNext;
            bRdata    <= bRdNext;
            busyQ     <= busyNext;
            ownerQ    <= ownerNext;
            starveCnt <= cntNext;
        end
    end

    assign bus.ram_addr  = ramAddr;
    assign bus.ram_wdata = ramWdata;
    assign bus.ram_read  = ramRead;
    assign bus.ram_write = ramWrite;
    assign bus.a_done    = aDone;
    assign bus.b_done    = bDone;
    assign bus.a_rdata   = aRdata;
    assign bus.b_rdata   = bRdata;
    assign bus.busy      = busyQ;
    assign bus.owner     = ownerQ;
endmodule
